// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline definitions: scoreboard entry layout and the default depth and
// load-stage constants also used by the datapath forwarding mux decode.
package pipe_pkg;
  localparam int FWD_REGFILE    = 0;
  localparam int DEF_DEPTH      = 3;
  localparam int DEF_LOAD_STAGE = 3;
  // rd is stored at a fixed width wide enough for any supported REG_W
  localparam int SB_RD_W        = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               load;
  } sb_entry_t;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage issue bundle into the forwarding scoreboard and its hazard/forward results.
interface fwd_scoreboard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = $clog2(pipe_pkg::DEF_DEPTH + 1)
);
  logic                     issue_valid;
  logic                     issue_wr;
  logic                     issue_load;
  logic [REG_W-1:0]         issue_rd;
  logic [NUM_SRC-1:0]       src_used;
  logic [NUM_SRC*REG_W-1:0] src_addr;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
  logic [15:0]              stall_cnt;

  modport master (
    output issue_valid, issue_wr, issue_load, issue_rd, src_used, src_addr, flush,
    input  stall, fwd_sel_q, stall_cnt
  );
  modport slave (
    input  issue_valid, issue_wr, issue_load, issue_rd, src_used, src_addr, flush,
    output stall, fwd_sel_q, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Youngest-match priority search of one source address against the scoreboard.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                  en,
  input  logic [REG_W-1:0]      addr,
  input  sb_entry_t [DEPTH:1]   sb,
  output logic                  hit,
  output logic [SEL_W-1:0]      stage,
  output logic                  load
);
  always_comb begin
    hit   = 1'b0;
    stage = '0;
    load  = 1'b0;
    if (en && addr != '0) begin
      // oldest first so younger stages override; a write-stage match reads the regfile
      for (int s = DEPTH; s >= 1; s--) begin
        if (sb[s].valid && sb[s].rd == SB_RD_W'(addr)) begin
          hit   = (s != DEPTH);
          stage = (s != DEPTH) ? SEL_W'(s) : '0;
          load  = (s != DEPTH) & sb[s].load;
        end
      end
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight writes; resolves load-use stall and
// registers per-source forwarding selects for the consumer's EX cycle.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  fwd_scoreboard_if.slave io
);
  sb_entry_t [DEPTH:1]             ent_q, ent_d;
  logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel_q, fwd_sel_d;
  logic [15:0]                     stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]              hit, ld, haz;
  logic [NUM_SRC-1:0][SEL_W-1:0]   stg;
  logic                            stall, issue_ok;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .en    (io.issue_valid & io.src_used[k]),
      .addr  (io.src_addr[k*REG_W +: REG_W]),
      .sb    (ent_q),
      .hit   (hit[k]),
      .stage (stg[k]),
      .load  (ld[k])
    );
    // producer advances one stage by the consumer's EX, so compare s+1
    assign haz[k] = hit[k] & ld[k] & ((32'(stg[k]) + 32'd1) < 32'(LOAD_STAGE));
  end

  always_comb begin
    stall    = (|haz) & ~io.flush;
    issue_ok = io.issue_valid & ~stall & ~io.flush;

    ent_d[1] = '0;
    if (issue_ok && io.issue_wr && io.issue_rd != '0) begin
      ent_d[1].valid = 1'b1;
      ent_d[1].rd    = SB_RD_W'(io.issue_rd);
      ent_d[1].load  = io.issue_load;
    end
    for (int s = 2; s <= DEPTH; s++) ent_d[s] = ent_q[s-1];
    if (io.flush) ent_d[2] = '0;

    for (int k = 0; k < NUM_SRC; k++)
      fwd_sel_d[k] = (issue_ok && hit[k]) ? stg[k] + SEL_W'(1) : SEL_W'(FWD_REGFILE);

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q       <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign io.stall     = stall;
  assign io.fwd_sel_q = fwd_sel_q;
  assign io.stall_cnt = stall_cnt_q;
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the in-order MIPS pipeline. It tracks every in-flight register write in a shift-register scoreboard and resolves hazards for the instruction in ID against that scoreboard. It produces registered per-source forwarding selects, which are valid during the consumer's EX cycle, and a combinational load-use stall. It sits beside the ID/EX pipeline register and replaces purely combinational stage-pair comparison.

## Interface
Parameters:
- `REG_W`, 5: register address width.
- `NUM_SRC`, 2: source operands per instruction.
- `DEPTH`, 3: tracked stages after ID. Stage 1 is EX and stage `DEPTH` is the register-file write stage.
- `LOAD_STAGE`, 3: first stage whose pipeline-register output holds load data. Legal range is 2..`DEPTH`.
- `SEL_W`, `$clog2(DEPTH+1)`: forwarding select width.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `issue_valid`, in, 1: a real instruction is present in ID.
- `issue_wr`, in, 1: the ID instruction writes a register.
- `issue_load`, in, 1: the ID instruction is a load.
- `issue_rd`, in, `REG_W`: destination register of the ID instruction.
- `src_used`, in, `NUM_SRC`: per-source "reads a register" flag.
- `src_addr`, in, `NUM_SRC*REG_W`: source addresses. Source k occupies bits [k*REG_W +: REG_W].
- `flush`, in, 1: kill the instruction in ID and the entry in stage 1.
- `stall`, out, 1: combinational. Hold IF and ID this cycle and insert a bubble into EX.
- `fwd_sel_q`, out, `NUM_SRC*SEL_W`: registered per-source select. 0 means register file; s means the output of the stage-s pipeline register.
- `stall_cnt`, out, 16: saturating count of stall cycles.

## Operation
- Scoreboard entry fields: {valid, rd, load}. There is one entry per stage 1..`DEPTH`, and the entries shift one stage every cycle. The pipeline never freezes past ID.
- Stage-1 entry load rule:
  - The entry takes {1, `issue_rd`, `issue_load`} when `issue_valid & issue_wr & issue_rd!=0 & ~stall & ~flush`.
  - Otherwise stage 1 loads a bubble (valid=0).
  - `flush` also clears the entry that would shift from stage 1 into stage 2.
- Per source k, evaluated only when `issue_valid & src_used[k]`:
  - Find the youngest matching stage s in 1..`DEPTH`-1: the lowest s with valid, `rd == src_addr[k]`, and `src_addr[k] != 0`.
  - A stage-`DEPTH` match is ignored. The register file is write-before-read, so that value is read directly.
  - Hazard(k) is true when the matching entry is a load and `s+1 < LOAD_STAGE`.
- `stall` is the OR of all Hazard(k), masked by `~flush`. The flush wins.
- `fwd_sel_q[k]` load rule:
  - It loads s+1 when the instruction actually issues (`issue_valid & ~stall & ~flush`) and source k matched.
  - It loads 0 in every other issue case.
  - On a cycle where the instruction does not issue, it loads 0.
- `stall_cnt` increments on every cycle where `stall` is high and saturates at 16'hFFFF.

## Timing
- Reset values: all entries invalid, `fwd_sel_q`=0, `stall_cnt`=0. `stall` is 0 whenever the scoreboard is empty.
- `stall` has zero latency: it is combinational from the ID inputs and the scoreboard.
- `fwd_sel_q` has one-cycle latency and is valid during the consumer's EX cycle. At that point the producer has advanced one stage, hence the encoding s+1.
- Load-use case (defaults): the load is in stage 1 while the consumer is in ID, giving s+1=2 < 3. This produces one stall cycle. On the next cycle the load is in stage 2 and s+1=3, so there is no hazard and the select is 3.
- Several sources may stall on the same cycle. This still costs a single stall cycle per cycle; stalls do not double-count.
- `reset` asserted mid-operation clears everything immediately. The first cycle after release behaves as if the pipeline were empty.

## Structure
- The shared package `pipe_pkg` holds:
  - the scoreboard entry typedef;
  - `FWD_REGFILE` = 0;
  - default `DEPTH`/`LOAD_STAGE` constants, shared with the datapath mux decode.
- One sub-module, `fwd_match`, is instantiated `NUM_SRC` times. It is a combinational youngest-match priority search returning {hit, stage, load}.

## Test plan
- Consecutive dependent ALU instructions: add r3 then sub r4,r3,r1. Required response: `stall`=0 and `fwd_sel_q[0]`=2.
- One independent instruction between producer and consumer: `fwd_sel_q`=3. Two independent instructions between them: `fwd_sel_q`=0.
- Load-use: lw r5 then add r6,r5,r5. Required response: `stall`=1 for exactly one cycle, `stall_cnt`=1, then both selects = 3.
- Producer with rd=0, or `issue_wr`=0: no forwarding and no stall. Two producers of r7 in stages 1 and 2: the select reflects stage 1 and equals 2.
- Load hazard with `flush` in the same cycle: `stall`=0, the stage-1 entry is cleared, and the next consumer of that register gets select 0.
- Assert `reset` with three entries valid: all selects go to 0, `stall_cnt` goes to 0, and there is no stall on the next dependent issue.
